tt_equiv_sweeper: RTL and testbench

//  Sequential equivalence checker for two N_IN-input Boolean functions supplied
//  as truth-table vectors (e.g. unsimplified vs simplified POS form). Steps an

---
 rtl/tt_equiv_sweeper.sv | 166 ++++++++++++++++
 tb/tb_tt_equiv_sweeper.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_equiv_sweeper.sv
// Exhaustive truth-table equivalence sweeper: walks all input rows of two
// latched tables, reporting each row and accumulating mismatch statistics.
module tt_equiv_sweeper #(
  parameter int N_IN = 4,
  localparam int ROWS = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            step_mode,
  input  logic            step,
  input  logic [ROWS-1:0] tt_a,
  input  logic [ROWS-1:0] tt_b,
  output logic            busy,
  output logic            done,
  output logic [N_IN-1:0] row_idx,
  output logic            sa,
  output logic            sb,
  output logic            row_mism,
  output logic [N_IN:0]   mism_cnt,
  output logic [N_IN-1:0] first_mism,
  output logic            first_vld,
  output logic            equal
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWEEP = 1'b1;
  localparam logic [N_IN-1:0] LAST = N_IN'(ROWS - 1);

  logic [0:0]      state_q, state_d;
  logic [N_IN-1:0] cnt_q, cnt_d;
  logic [ROWS-1:0] ta_q, ta_d;
  logic [ROWS-1:0] tb_q, tb_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N_IN-1:0] row_idx_q, row_idx_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            row_mism_q, row_mism_d;
  logic [N_IN:0]   mism_cnt_q, mism_cnt_d;
  logic [N_IN-1:0] first_mism_q, first_mism_d;
  logic            first_vld_q, first_vld_d;
  logic            equal_q, equal_d;

  logic          adv;
  logic          bit_a;
  logic          bit_b;
  logic          mis;
  logic [N_IN:0] cnt_sum;

  assign adv     = !step_mode || step;
  assign bit_a   = ta_q[cnt_q];
  assign bit_b   = tb_q[cnt_q];
  assign mis     = bit_a ^ bit_b;
  assign cnt_sum = mism_cnt_q + {{N_IN{1'b0}}, mis};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ta_d         = ta_q;
    tb_d         = tb_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    row_idx_d    = row_idx_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    row_mism_d   = row_mism_q;
    mism_cnt_d   = mism_cnt_q;
    first_mism_d = first_mism_q;
    first_vld_d  = first_vld_q;
    equal_d      = equal_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start && !abort) begin
          state_d      = S_SWEEP;
          ta_d         = tt_a;
          tb_d         = tt_b;
          cnt_d        = '0;
          busy_d       = 1'b1;
          row_idx_d    = '0;
          sa_d         = 1'b0;
          sb_d         = 1'b0;
          row_mism_d   = 1'b0;
          mism_cnt_d   = '0;
          first_mism_d = '0;
          first_vld_d  = 1'b0;
        end
      end
      (state_q == S_SWEEP): begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (adv) begin
          row_idx_d  = cnt_q;
          sa_d       = bit_a;
          sb_d       = bit_b;
          row_mism_d = mis;
          mism_cnt_d = cnt_sum;
          cnt_d      = cnt_q + 1'b1;
          if (mis && !first_vld_q) begin
            first_mism_d = cnt_q;
            first_vld_d  = 1'b1;
          end
          // Completion uses the count including the final row.
          if (cnt_q == LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            equal_d = (cnt_sum == '0);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ta_q         <= '0;
      tb_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      row_idx_q    <= '0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      row_mism_q   <= 1'b0;
      mism_cnt_q   <= '0;
      first_mism_q <= '0;
      first_vld_q  <= 1'b0;
      equal_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ta_q         <= ta_d;
      tb_q         <= tb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      row_idx_q    <= row_idx_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      row_mism_q   <= row_mism_d;
      mism_cnt_q   <= mism_cnt_d;
      first_mism_q <= first_mism_d;
      first_vld_q  <= first_vld_d;
      equal_q      <= equal_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign row_idx    = row_idx_q;
  assign sa         = sa_q;
  assign sb         = sb_q;
  assign row_mism   = row_mism_q;
  assign mism_cnt   = mism_cnt_q;
  assign first_mism = first_mism_q;
  assign first_vld  = first_vld_q;
  assign equal      = equal_q;

endmodule

// File: tb/tb_tt_equiv_sweeper.sv
// Bench for tt_equiv_sweeper: directed and random tables against a
// row-by-row reference computed straight from the two tables.
module tb_tt_equiv_sweeper;

  localparam int N = 4;
  localparam int R = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         step_mode = 1'b0;
  logic         step = 1'b0;
  logic [R-1:0] tt_a = '0;
  logic [R-1:0] tt_b = '0;
  logic         busy, done, sa, sb, row_mism, first_vld, equal;
  logic [N-1:0] row_idx, first_mism;
  logic [N:0]   mism_cnt;

  int tests = 0;
  int fails = 0;
  logic exp_equal = 1'b0;

  tt_equiv_sweeper #(.N_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .step_mode(step_mode), .step(step), .tt_a(tt_a), .tt_b(tt_b),
    .busy(busy), .done(done), .row_idx(row_idx), .sa(sa), .sb(sb),
    .row_mism(row_mism), .mism_cnt(mism_cnt), .first_mism(first_mism),
    .first_vld(first_vld), .equal(equal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full free-run sweep; tables are scrambled after the start edge.
  task automatic sweep(input logic [R-1:0] a, input logic [R-1:0] b);
    int cnt;
    int first;
    tt_a = a;
    tt_b = b;
    step_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tt_a = R'($urandom);
    tt_b = R'($urandom);
    chk("start_busy", 32'(busy), 1);
    chk("start_cnt", 32'(mism_cnt), 0);
    chk("start_fvld", 32'(first_vld), 0);
    chk("start_eq_hold", 32'(equal), 32'(exp_equal));
    cnt = 0;
    first = -1;
    for (int i = 0; i < R; i++) begin
      tick();
      if (a[i] != b[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
      chk("row_idx", 32'(row_idx), i);
      chk("sa", 32'(sa), 32'(a[i]));
      chk("sb", 32'(sb), 32'(b[i]));
      chk("row_mism", 32'(row_mism), 32'(a[i] != b[i]));
      chk("mism_cnt", 32'(mism_cnt), cnt);
      chk("first_vld", 32'(first_vld), 32'(first >= 0));
      if (first >= 0) chk("first_mism", 32'(first_mism), first);
      chk("done", 32'(done), 32'(i == R - 1));
      chk("busy", 32'(busy), 32'(i != R - 1));
      if (i != R - 1) chk("eq_hold", 32'(equal), 32'(exp_equal));
    end
    exp_equal = (a == b);
    chk("equal", 32'(equal), 32'(exp_equal));
    tick();
    chk("done_pulse", 32'(done), 0);
    chk("hold_cnt", 32'(mism_cnt), cnt);
    chk("hold_row", 32'(row_idx), R - 1);
  endtask

  initial begin
    int nsteps;
    logic [R-1:0] ra, rb;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_equal", 32'(equal), 0);
    chk("rst_cnt", 32'(mism_cnt), 0);
    chk("rst_row", 32'(row_idx), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    sweep(16'h5F59, 16'h5F55);
    sweep(16'h5F55, 16'h5F55);

    // Abort at row 7 with start and step also asserted.
    tt_a = 16'h5F59;
    tt_b = 16'h5F55;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_abort_row", 32'(row_idx), 6);
    abort = 1'b1;
    start = 1'b1;
    step = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    step = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_cnt", 32'(mism_cnt), 2);
    chk("abort_row", 32'(row_idx), 6);
    chk("abort_eq", 32'(equal), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_nodone", 32'(done), 0);
    end
    chk("abort_idle", 32'(busy), 0);
    sweep(16'h5F59, 16'h5F55);

    sweep(16'h0000, 16'hFFFF);

    // Single-step: three pulses over ten cycles.
    tt_a = 16'h5F59;
    tt_b = 16'h5F55;
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    nsteps = 0;
    for (int c = 0; c < 10; c++) begin
      step = (c == 1 || c == 4 || c == 7);
      tick();
      if (step) begin
        nsteps++;
        chk("step_row", 32'(row_idx), nsteps - 1);
      end
      chk("step_nodone", 32'(done), 0);
    end
    step = 1'b0;
    chk("step_busy", 32'(busy), 1);
    chk("step_last", 32'(row_idx), 2);
    chk("step_cnt", 32'(mism_cnt), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("step_abort", 32'(busy), 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("idle_step", 32'(busy), 0);
    step_mode = 1'b0;

    for (int k = 0; k < 6; k++) begin
      ra = R'($urandom);
      rb = (k % 3 == 0) ? ra : (ra ^ R'($urandom_range(0, 3) << $urandom_range(0, 12)));
      sweep(ra, rb);
    end

    sweep(16'h5F55, 16'h5F55);
    // Reset mid-sweep, with a stray start during the sweep.
    tt_a = 16'h5F59;
    tt_b = 16'h5F55;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start = (i == 3);
      tick();
      chk("mid_start_row", 32'(row_idx), i);
    end
    start = 1'b0;
    chk("pre_rst_cnt", 32'(mism_cnt), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_row", 32'(row_idx), 0);
    chk("arst_cnt", 32'(mism_cnt), 0);
    chk("arst_equal", 32'(equal), 0);
    chk("arst_fvld", 32'(first_vld), 0);
    chk("arst_done", 32'(done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(done), 0);
    exp_equal = 1'b0;
    sweep(16'h0F0F, 16'h0F0E);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
